// File: rtl/cci_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cci_pkg : shared types and constants for the CCI init sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package cci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWRUP    = 3'd1,
    ST_FETCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_GAP      = 3'd5,
    ST_NEXT     = 3'd6,
    ST_SETTLE   = 3'd7
  } cci_state_e;

  localparam logic [1:0] c_idx_dev  = 2'd0;
  localparam logic [1:0] c_idx_ahi  = 2'd1;
  localparam logic [1:0] c_idx_alo  = 2'd2;
  localparam logic [1:0] c_idx_data = 2'd3;

  localparam logic [7:0] c_dev_wr_default = 8'h20;

endpackage
`default_nettype wire

// File: rtl/cci_delay_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cci_delay_timer : loadable down-counter with zero flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module cci_delay_timer
  import cci_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cci_init_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cci_init_sequencer : walks the sensor init table and writes each entry over CCI
// Revision: 1.0
// ---------------------------------------------------------------------------
module cci_init_sequencer
  import cci_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = c_dev_wr_default[7:1],
  parameter int         PWRUP_CYCLES   = 1000,
  parameter int         GAP_CYCLES     = 200,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [5:0]  o_err_step,
  output logic        o_tbl_run_init,
  output logic        o_tbl_step_increment,
  output logic        o_tbl_read_enable,
  input  logic [15:0] i_tbl_addr,
  input  logic [7:0]  i_tbl_data,
  input  logic        i_tbl_complete,
  output logic        o_i2c_cmd_valid,
  input  logic        i_i2c_cmd_ready,
  output logic        o_i2c_cmd_start,
  output logic        o_i2c_cmd_stop,
  output logic [7:0]  o_i2c_cmd_data,
  input  logic        i_i2c_rsp_valid,
  input  logic        i_i2c_rsp_nack
);

  localparam int          RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] c_pwrup_ld  = 16'(PWRUP_CYCLES - 1);
  localparam logic [15:0] c_gap_ld    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] c_tmo_ld    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] c_settle_ld = 16'd1;
  localparam logic [7:0]  c_dev_wr    = {DEV_ADDR, 1'b0};

  cci_state_e       r_state;
  cci_state_e       w_state_nxt;
  logic [15:0]      r_addr;
  logic [7:0]       r_data;
  logic [1:0]       r_idx;
  logic [RW-1:0]    r_retry;
  logic             r_ok;
  logic [5:0]       r_step;
  logic             r_done;
  logic             r_error;
  logic [5:0]       r_err_step;

  logic             w_tmr_load;
  logic [15:0]      w_tmr_val;
  logic             w_tmr_zero;
  logic             w_rsp_ack;
  logic             w_retry_left;
  logic             w_send;
  logic [7:0]       w_byte;
  logic             w_first;
  logic             w_last;

  assign w_rsp_ack    = i_i2c_rsp_valid && !i_i2c_rsp_nack;
  assign w_retry_left = (int'(r_retry) < MAX_RETRY);
  assign w_send       = (r_state == ST_SEND);

  cci_delay_timer #(
    .WIDTH (16)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Every counted state is entered with the timer loaded to N-1, so it lasts exactly N cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_PWRUP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_pwrup_ld;
        end
      end
      ST_PWRUP: begin
        if (w_tmr_zero) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = i_tbl_complete ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (i_i2c_cmd_ready) begin
          w_state_nxt = ST_WAIT_RSP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_tmo_ld;
        end
      end
      ST_WAIT_RSP: begin
        // The response is checked before the timeout so a same-cycle response wins.
        if (w_rsp_ack && (r_idx != c_idx_data)) begin
          w_state_nxt = ST_SEND;
        end else if (i_i2c_rsp_valid || w_tmr_zero) begin
          w_state_nxt = ST_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_gap_ld;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          if (r_ok)              w_state_nxt = ST_NEXT;
          else if (w_retry_left) w_state_nxt = ST_SEND;
          else                   w_state_nxt = ST_IDLE;
        end
      end
      ST_NEXT: begin
        w_state_nxt = ST_SETTLE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = c_settle_ld;
      end
      ST_SETTLE: begin
        if (w_tmr_zero) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_idx      <= c_idx_dev;
      r_retry    <= '0;
      r_ok       <= 1'b0;
      r_step     <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_step <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_step  <= '0;
          end
        end
        ST_FETCH: begin
          if (i_tbl_complete) begin
            r_done <= 1'b1;
          end else begin
            r_addr  <= i_tbl_addr;
            r_data  <= i_tbl_data;
            r_retry <= '0;
            r_idx   <= c_idx_dev;
            r_ok    <= 1'b0;
          end
        end
        ST_WAIT_RSP: begin
          if (w_rsp_ack) begin
            if (r_idx == c_idx_data) r_ok  <= 1'b1;
            else                     r_idx <= r_idx + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_tmr_zero && !r_ok) begin
            if (w_retry_left) begin
              r_retry <= r_retry + 1'b1;
              r_idx   <= c_idx_dev;
            end else begin
              r_error    <= 1'b1;
              r_err_step <= r_step;
            end
          end
        end
        ST_NEXT: r_step <= r_step + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte  = 8'h00;
    w_first = 1'b0;
    w_last  = 1'b0;
    case (r_idx)
      c_idx_dev: begin
        w_byte  = c_dev_wr;
        w_first = 1'b1;
      end
      c_idx_ahi:  w_byte = r_addr[15:8];
      c_idx_alo:  w_byte = r_addr[7:0];
      c_idx_data: begin
        w_byte = r_data;
        w_last = 1'b1;
      end
      default: w_byte = 8'h00;
    endcase
  end

  // Command fields are gated by valid so every output reads 0 outside SEND.
  assign o_i2c_cmd_valid      = w_send;
  assign o_i2c_cmd_data       = w_send ? w_byte : 8'h00;
  assign o_i2c_cmd_start      = w_send && w_first;
  assign o_i2c_cmd_stop       = w_send && w_last;
  assign o_busy               = (r_state != ST_IDLE);
  assign o_done               = r_done;
  assign o_error              = r_error;
  assign o_err_step           = r_err_step;
  assign o_tbl_run_init       = (r_state != ST_IDLE);
  assign o_tbl_read_enable    = o_tbl_run_init;
  assign o_tbl_step_increment = (r_state == ST_NEXT);

endmodule
`default_nettype wire

// File: tb/tb_cci_init_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cci_init_sequencer : scoreboard bench with table and I2C byte-engine models
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cci_init_sequencer;

  localparam int PWRUP = 20;
  localparam int GAP   = 20;
  localparam int MAXR  = 3;
  localparam int TMO   = 64;
  localparam int NENT  = 59;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack = 1'b0;
  logic [15:0] tbl_addr = '0;
  logic [7:0]  tbl_data = '0;
  logic        tbl_complete = 1'b0;
  logic        busy, done, error, run_init, step_inc, rd_en;
  logic        valid, cmd_start, cmd_stop;
  logic [5:0]  err_step;
  logic [7:0]  cmd_data;
  logic [22:0] outs;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [9:0]  exp_q[$];
  int          cyc = 0;
  int          m_step = 0;
  int          bytes_acc = 0;
  int          stops_acc = 0;
  int          pulses = 0;
  int          pos = 0;
  int          rsp_cnt = 0;
  logic        rsp_nack_pend = 1'b0;
  int          f_entry = -1;
  int          f_pos = 0;
  int          f_limit = 0;
  int          f_base = 0;
  int          f_inj = 0;
  logic        f_drop = 1'b0;
  int          t_drop = -1;
  int          n_tmo_seen = 0;
  logic        hold_prev = 1'b0;
  logic [9:0]  word_prev = '0;

  always #5 clk = ~clk;

  cci_init_sequencer #(
    .DEV_ADDR       (7'h10),
    .PWRUP_CYCLES   (PWRUP),
    .GAP_CYCLES     (GAP),
    .MAX_RETRY      (MAXR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_start              (start),
    .o_busy               (busy),
    .o_done               (done),
    .o_error              (error),
    .o_err_step           (err_step),
    .o_tbl_run_init       (run_init),
    .o_tbl_step_increment (step_inc),
    .o_tbl_read_enable    (rd_en),
    .i_tbl_addr           (tbl_addr),
    .i_tbl_data           (tbl_data),
    .i_tbl_complete       (tbl_complete),
    .o_i2c_cmd_valid      (valid),
    .i_i2c_cmd_ready      (ready),
    .o_i2c_cmd_start      (cmd_start),
    .o_i2c_cmd_stop       (cmd_stop),
    .o_i2c_cmd_data       (cmd_data),
    .i_i2c_rsp_valid      (rsp_valid),
    .i_i2c_rsp_nack       (rsp_nack)
  );

  assign outs = {busy, done, error, err_step, run_init, step_inc, rd_en,
                 valid, cmd_start, cmd_stop, cmd_data};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Representative 59-entry table: fixed head and tail, synthetic middle entries.
  function automatic logic [23:0] tbl_entry(input int i);
    logic [15:0] v;
    v = 16'(i);
    case (i)
      0:       return {16'h0100, 8'h00};
      1:       return {16'h30EB, 8'h05};
      2:       return {16'h30EB, 8'h0C};
      3:       return {16'h012A, 8'h18};
      4:       return {16'h012B, 8'h00};
      58:      return {16'h0100, 8'h01};
      default: return {16'h0160 + v, v[7:0] ^ 8'h5A};
    endcase
  endfunction

  // Expected command word {start, stop, data} for byte b of an entry.
  function automatic logic [9:0] byte_word(input logic [23:0] a, input int b);
    case (b)
      0:       return {2'b10, 8'h20};
      1:       return {2'b00, a[23:16]};
      2:       return {2'b00, a[15:8]};
      default: return {2'b01, a[7:0]};
    endcase
  endfunction

  task automatic setup_fault(input int e, input int p, input int l, input logic d);
    f_entry = e;
    f_pos   = p;
    f_limit = l;
    f_drop  = d;
    f_base  = f_inj;
  endtask

  task automatic build_exp();
    int          fails;
    logic [23:0] a;
    exp_q.delete();
    for (int e = 0; e < NENT; e++) begin
      a = tbl_entry(e);
      if (e == f_entry) begin
        fails = (f_limit > MAXR + 1) ? MAXR + 1 : f_limit;
        for (int k = 0; k < fails; k++)
          for (int b = 0; b <= f_pos; b++) exp_q.push_back(byte_word(a, b));
        if (fails == MAXR + 1) return;
      end
      for (int b = 0; b < 4; b++) exp_q.push_back(byte_word(a, b));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_start(input string tag);
    pulse_start();
    @(negedge clk);
    check_val({tag, "_busy_high"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Table model (registered output, one-cycle step update) and byte-engine model.
  initial begin : bfm
    logic       s_run, s_inc, s_valid, s_ready;
    logic [9:0] w;
    int         old;
    forever begin
      @(negedge clk);
      cyc++;
      s_run   = run_init;
      s_inc   = step_inc;
      s_valid = valid;
      s_ready = ready;
      w       = {cmd_start, cmd_stop, cmd_data};
      if (!rst) begin
        if (hold_prev && s_valid) check_val("hold_stable", 32'(w), 32'(word_prev));
        hold_prev = s_valid && !s_ready;
        word_prev = w;
        if (s_inc) pulses++;
        // Acceptance cycle, then TIMEOUT wait cycles and GAP cycles before the retry byte.
        if (t_drop >= 0 && s_valid && cyc > t_drop) begin
          check_val("timeout_retry_delay", cyc - t_drop, TMO + GAP + 1);
          t_drop = -1;
          n_tmo_seen++;
        end
        if (s_valid && s_ready) begin
          bytes_acc++;
          if (cmd_stop) stops_acc++;
          pos = cmd_start ? 0 : pos + 1;
          if (exp_q.size() == 0) check_val("byte_unexpected", exp_q.size(), 1);
          else check_val($sformatf("byte_e%0d_p%0d", m_step, pos), 32'(w), 32'(exp_q.pop_front()));
          if (m_step == f_entry && pos == f_pos && (f_inj - f_base) < f_limit) begin
            f_inj++;
            if (f_drop) begin
              t_drop = cyc;
            end else begin
              rsp_cnt       = 3;
              rsp_nack_pend = 1'b1;
            end
          end else begin
            rsp_cnt       = 3;
            rsp_nack_pend = 1'b0;
          end
        end
      end else begin
        hold_prev = 1'b0;
      end
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (rst) begin
        m_step       = 0;
        rsp_cnt      = 0;
        tbl_addr     = '0;
        tbl_data     = '0;
        tbl_complete = 1'b0;
      end else begin
        old = m_step;
        {tbl_addr, tbl_data} = tbl_entry(old);
        tbl_complete = (old >= NENT);
        if (!s_run)     m_step = 0;
        else if (s_inc) m_step++;
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_nack  = rsp_nack_pend;
          end
        end
      end
    end
  end

  initial begin : main
    int   b0, s0, p0, bh, t0, n;
    logic reached;

    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'(outs), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Clean full run with a stray start pulse mid-sequence.
    setup_fault(-1, 0, 0, 1'b0);
    build_exp();
    b0 = bytes_acc; s0 = stops_acc; p0 = pulses;
    run_start("r1");
    n = 0;
    while ((pulses - p0) < 20 && n < 20000) begin
      @(posedge clk); #2;
      n++;
    end
    pulse_start();
    wait_idle("r1");
    check_val("r1_bytes", bytes_acc - b0, 236);
    check_val("r1_txns", stops_acc - s0, NENT);
    check_val("r1_pulses", pulses - p0, NENT);
    check_val("r1_done", 32'(done), 32'd1);
    check_val("r1_error", 32'(error), 32'd0);
    check_val("r1_exp_left", exp_q.size(), 0);

    // Single NACK on byte1 of entry 3, plus ready held low during byte2 of entry 1.
    setup_fault(3, 1, 1, 1'b0);
    build_exp();
    b0 = bytes_acc; p0 = pulses;
    run_start("r2");
    n = 0;
    while ((bytes_acc - b0) < 6 && n < 20000) begin
      @(posedge clk); #2;
      n++;
    end
    check_val("r2_hold_reached", bytes_acc - b0, 6);
    ready = 1'b0;
    bh = bytes_acc;
    repeat (100) @(negedge clk);
    check_val("r2_hold_no_accept", bytes_acc - bh, 0);
    check_val("r2_hold_valid", 32'(valid), 32'd1);
    @(posedge clk); #2 ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("r2_hold_one_accept", bytes_acc - bh, 1);
    wait_idle("r2");
    check_val("r2_bytes", bytes_acc - b0, 238);
    check_val("r2_pulses", pulses - p0, NENT);
    check_val("r2_done", 32'(done), 32'd1);
    check_val("r2_error", 32'(error), 32'd0);
    check_val("r2_exp_left", exp_q.size(), 0);

    // Persistent NACK on entry 5.
    setup_fault(5, 0, 100, 1'b0);
    build_exp();
    b0 = bytes_acc; p0 = pulses;
    run_start("r3");
    wait_idle("r3");
    check_val("r3_error", 32'(error), 32'd1);
    check_val("r3_err_step", 32'(err_step), 32'd5);
    check_val("r3_done", 32'(done), 32'd0);
    check_val("r3_bytes", bytes_acc - b0, 24);
    check_val("r3_pulses", pulses - p0, 5);
    check_val("r3_exp_left", exp_q.size(), 0);
    repeat (50) @(negedge clk);
    check_val("r3_pulses_after", pulses - p0, 5);
    check_val("r3_busy_after", 32'(busy), 32'd0);

    // Dropped response on entry 2 exercises the timeout path.
    setup_fault(2, 0, 1, 1'b1);
    build_exp();
    b0 = bytes_acc; t0 = n_tmo_seen;
    run_start("r4");
    wait_idle("r4");
    check_val("r4_retry_seen", n_tmo_seen - t0, 1);
    check_val("r4_bytes", bytes_acc - b0, 237);
    check_val("r4_done", 32'(done), 32'd1);
    check_val("r4_error", 32'(error), 32'd0);
    check_val("r4_exp_left", exp_q.size(), 0);

    // Reset in the middle of entry 10.
    setup_fault(-1, 0, 0, 1'b0);
    build_exp();
    run_start("r5");
    n = 0;
    reached = 1'b0;
    while (!reached && n < 20000) begin
      @(posedge clk); #2;
      reached = (m_step == 10) && valid;
      n++;
    end
    check_val("r5_reached_entry10", 32'(reached), 32'd1);
    rst = 1'b1;
    #1;
    check_val("r5_reset_outputs", 32'(outs), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();

    // Fresh start after reset reruns from entry 0.
    build_exp();
    b0 = bytes_acc; p0 = pulses;
    run_start("r6");
    wait_idle("r6");
    check_val("r6_bytes", bytes_acc - b0, 236);
    check_val("r6_pulses", pulses - p0, NENT);
    check_val("r6_done", 32'(done), 32'd1);
    check_val("r6_exp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
